// File: rtl/gen_pipefifo_pkg.sv
// rtl/gen_pipefifo_pkg.sv - pointer status helpers for the registered ready/valid FIFO
package gen_pipefifo_pkg;

    // Full when the pointers differ in the wrap bit only (pointers zero-extended to 32 bits)
    function automatic logic ptr_full(input logic [31:0] rp, input logic [31:0] wp, input int unsigned aw);
        return ((rp ^ wp) == (32'd1 << aw));
    endfunction

    // Empty when both pointers are identical, wrap bit included
    function automatic logic ptr_empty(input logic [31:0] rp, input logic [31:0] wp);
        return (rp == wp);
    endfunction

endpackage

// File: rtl/gen_dffr.sv
// rtl/gen_dffr.sv - DW-bit register, synchronous active-low reset to zero
module gen_dffr #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout,
    input  logic          clk,
    input  logic          rst_n
);

    logic [DW-1:0] r_q;

    // Load every cycle; clear on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= dnxt;
        end
    end

    assign qout = r_q;

endmodule

// File: rtl/gen_dffren.sv
// rtl/gen_dffren.sv - DW-bit register with load enable, synchronous active-low reset to zero
module gen_dffren #(
    parameter int DW = 32
) (
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout,
    input  logic          clk,
    input  logic          rst_n
);

    logic [DW-1:0] r_q;

    // Load only when enabled; clear on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (lden) begin
            r_q <= dnxt;
        end
    end

    assign qout = r_q;

endmodule

// File: rtl/gen_pipefifo.sv
// rtl/gen_pipefifo.sv - registered multi-entry ready/valid FIFO with flush; option GEN_PIPEFIFO_FULLPASS_EN
module gen_pipefifo
    import gen_pipefifo_pkg::*;
#(
    parameter int DW = 64,
    parameter int DP = 4
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   valid_i,
    input  logic [DW-1:0]          data_i,
    output logic                   ready_i,
    output logic                   valid_o,
    output logic [DW-1:0]          data_o,
    input  logic                   ready_o,
    input  logic                   flush,
    output logic [$clog2(DP):0]    cnt
);

    localparam int AW = $clog2(DP);
    localparam int PW = AW + 1;

    logic [PW-1:0] w_rp;
    logic [PW-1:0] w_wp;
    logic [PW-1:0] w_rp_nxt;
    logic [PW-1:0] w_wp_nxt;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [DW-1:0] w_mem [DP];

    assign w_full  = ptr_full(32'(w_rp), 32'(w_wp), AW);
    assign w_empty = ptr_empty(32'(w_rp), 32'(w_wp));

`ifdef GEN_PIPEFIFO_FULLPASS_EN
    // A pop frees the head slot in the same cycle, so a full FIFO may still accept
    assign ready_i = ~w_full | ready_o;
`else
    assign ready_i = ~w_full;
`endif

    assign valid_o = ~w_empty;
    assign w_push  = valid_i & ready_i & ~flush;
    assign w_pop   = valid_o & ready_o & ~flush;

    // Flush returns both pointers to zero; otherwise each advances on its handshake
    always_comb begin
        w_rp_nxt = w_rp + PW'(w_pop);
        w_wp_nxt = w_wp + PW'(w_push);
        if (flush) begin
            w_rp_nxt = '0;
            w_wp_nxt = '0;
        end
    end

    gen_dffr #(.DW(PW)) u_rp (
        .dnxt  (w_rp_nxt),
        .qout  (w_rp),
        .clk   (CLK),
        .rst_n (RSTn)
    );

    gen_dffr #(.DW(PW)) u_wp (
        .dnxt  (w_wp_nxt),
        .qout  (w_wp),
        .clk   (CLK),
        .rst_n (RSTn)
    );

    // One enabled register per entry, written when the push targets that slot
    for (genvar gi = 0; gi < DP; gi++) begin : g_entry
        logic w_sel;
        assign w_sel = w_push & (w_wp[AW-1:0] == AW'(gi));
        gen_dffren #(.DW(DW)) u_ent (
            .lden  (w_sel),
            .dnxt  (data_i),
            .qout  (w_mem[gi]),
            .clk   (CLK),
            .rst_n (RSTn)
        );
    end

    assign data_o = w_mem[w_rp[AW-1:0]];
    assign cnt    = w_wp - w_rp;

endmodule

// File: tb/tb_gen_pipefifo.sv
// tb/tb_gen_pipefifo.sv - scoreboard bench for gen_pipefifo (DW=8, DP=4); honours GEN_PIPEFIFO_FULLPASS_EN
module tb_gen_pipefifo;

    logic       CLK;
    logic       RSTn;
    logic       valid_i;
    logic [7:0] data_i;
    logic       ready_i;
    logic       valid_o;
    logic [7:0] data_o;
    logic       ready_o;
    logic       flush;
    logic [2:0] cnt;

    int n_cmp;
    int n_bad;
    int m_cnt;
    logic [7:0] sb_q[$];

    gen_pipefifo #(.DW(8), .DP(4)) dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_i (ready_i),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_o (ready_o),
        .flush   (flush),
        .cnt     (cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output handshake must match the oldest expected beat
    always @(negedge CLK) begin
        if (RSTn === 1'b1 && flush === 1'b0 && valid_o === 1'b1 && ready_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: got data 0x%0h with no expected beat", data_o);
            end else begin
                chk("data_o", int'(data_o), int'(sb_q.pop_front()));
            end
        end
    end

    // One clock of stimulus; model predicts status and acceptance independently
    task automatic step(input logic rn, input logic v, input logic [7:0] d, input logic r, input logic f);
        logic m_rdy;
        logic m_push;
        logic m_pop;
        RSTn    = rn;
        valid_i = v;
        data_i  = d;
        ready_o = r;
        flush   = f;
`ifdef GEN_PIPEFIFO_FULLPASS_EN
        m_rdy = (m_cnt < 4) || r;
`else
        m_rdy = (m_cnt < 4);
`endif
        m_push = v && m_rdy && !f && rn;
        m_pop  = (m_cnt != 0) && r && !f && rn;
        @(negedge CLK);
        chk("cnt", int'(cnt), m_cnt);
        chk("ready_i", int'(ready_i), int'(m_rdy));
        chk("valid_o", int'(valid_o), int'(m_cnt != 0));
        if (!rn || f) begin
            sb_q.delete();
        end else if (m_push) begin
            sb_q.push_back(d);
        end
        @(posedge CLK);
        if (!rn || f) m_cnt = 0;
        else m_cnt = m_cnt + int'(m_push) - int'(m_pop);
        #1;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        m_cnt   = 0;
        RSTn    = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        ready_o = 1'b0;
        flush   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b1;

        // Idle after reset
        repeat (5) step(1, 0, 8'h00, 0, 0);
        chk("data_o_reset", int'(data_o), 0);

        // Fill with no drain, offer a fifth beat, then drain in order
        step(1, 1, 8'h11, 0, 0);
        step(1, 1, 8'h22, 0, 0);
        step(1, 1, 8'h33, 0, 0);
        step(1, 1, 8'h44, 0, 0);
        step(1, 1, 8'h55, 0, 0);
        chk("cnt_full", int'(cnt), 4);
        repeat (5) step(1, 0, 8'h00, 1, 0);

        // Streaming 0x00..0x0F with continuous drain
        for (int i = 0; i < 16; i++) step(1, 1, 8'(i), 1, 0);
        repeat (2) step(1, 0, 8'h00, 1, 0);

        // Flush with a concurrent push and pop
        step(1, 1, 8'hA1, 0, 0);
        step(1, 1, 8'hA2, 0, 0);
        step(1, 1, 8'hA3, 0, 0);
        step(1, 1, 8'h99, 1, 1);
        step(1, 0, 8'h00, 1, 0);

        // Full FIFO with drain and a new beat offered
        step(1, 1, 8'hB1, 0, 0);
        step(1, 1, 8'hB2, 0, 0);
        step(1, 1, 8'hB3, 0, 0);
        step(1, 1, 8'hB4, 0, 0);
        step(1, 1, 8'hAA, 1, 0);
`ifdef GEN_PIPEFIFO_FULLPASS_EN
        step(1, 0, 8'h00, 0, 0);
`else
        step(1, 1, 8'hAA, 0, 0);
`endif
        chk("cnt_after_full_pass", int'(cnt), 4);
        repeat (5) step(1, 0, 8'h00, 1, 0);

        // Reset in the middle of traffic
        step(1, 1, 8'hC1, 0, 0);
        step(1, 1, 8'hC2, 0, 0);
        step(0, 1, 8'hC3, 1, 0);
        step(1, 0, 8'h00, 0, 0);
        chk("data_o_midreset", int'(data_o), 0);
        chk("sb_empty_end", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gen_pipefifo.md
# gen_pipefifo

Registered multi-entry ready/valid FIFO: the buffering counterpart to the pass-through bypass FIFO. Data is never forwarded combinationally from input to output, so both the data path and `ready_i` are cut by flip-flops. Placed at pipeline-stage boundaries where a true register stage with elasticity is required, such as between issue and execute queues or on the bus response return. Supports a synchronous flush for pipeline kill.

## Interface
- `DW`, 64, data width in bits
- `DP`, 4, depth in entries; power of two, ≥2
- `CLK`  in  1  clock; all state updates on rising edge
- `RSTn`  in  1  reset, synchronous, active-low
- `valid_i`  in  1  upstream valid
- `data_i`  in  DW  upstream data
- `ready_i`  out  1  FIFO can accept this cycle
- `valid_o`  out  1  head entry valid
- `data_o`  out  DW  head entry data
- `ready_o`  in  1  downstream accepts head
- `flush`  in  1  discard all contents
- `cnt`  out  $clog2(DP)+1  current occupancy, 0..DP

## Operation
- Storage is `DP` entries of `DW` bits. Read pointer `rp` and write pointer `wp` are each `$clog2(DP)+1` bits; the MSB is the wrap bit.
- `empty` = (`rp` == `wp`). `full` = MSBs differ and low bits equal. `cnt` = `wp` − `rp`, modulo 2^(AW+1).
- Push = `valid_i & ready_i & ~flush`: writes `data_i` to `mem[wp[AW-1:0]]`, then `wp`+1.
- Pop = `valid_o & ready_o & ~flush`: `rp`+1.
- Push and pop in the same cycle are both performed; `cnt` is unchanged.
- `ready_i` = `~full`, or as modified under Configuration.
- `valid_o` = `~empty`. `data_o` = `mem[rp[AW-1:0]]`, a mux over registered entries only.
- `flush`: next edge sets `rp`=`wp`=0. Any push or pop in the flush cycle is ignored. Storage contents are not cleared.
- `valid_i` asserted while `ready_i`=0 is legal. The beat is held upstream and not written.
- Pointer wrap: the low bits roll from DP−1 to 0 and the wrap bit toggles. No other special case.

## Timing
- Reset (`RSTn`=0 at an edge): `rp`=`wp`=0 and all storage entries = 0. After reset: `valid_o`=0, `data_o`=0, `ready_i`=1, `cnt`=0.
- Reset has priority over `flush`, which has priority over push and pop. Reset asserted mid-stream discards all contents at that edge.
- Latency: a beat pushed at edge t is visible on `valid_o`/`data_o` immediately after edge t. There is a minimum one-cycle gap between input and output handshakes, with no same-cycle pass-through.
- Throughput: one beat per cycle sustained when `ready_o`=1 continuously.
- `cnt`, `valid_o` and `ready_i` (base mode) are functions of registered pointers only.
- Flush in cycle t: after edge t, `valid_o`=0, `cnt`=0, `ready_i`=1.

## Configuration
- `GEN_PIPEFIFO_FULLPASS_EN`
  - Defined: `ready_i` = `~full | ready_o`. When full and the head is popped, a push is accepted in the same cycle, writing into the slot freed by the pop; `cnt` stays DP. Sustains full throughput at DP occupancy, at the cost of a combinational `ready_o`→`ready_i` path.
  - Undefined: `ready_i` = `~full` (fully registered). A full FIFO accepts a new beat only in the cycle after a pop.

## Structure
- No package types needed. `AW` = `$clog2(DP)` and the pointer width `AW+1` are localparams inside the module.
- Each storage entry is one instance of the existing `gen_dffren` (width `DW`), enabled by the push strobe AND the entry-select decode.
- Pointers are `gen_dffr` instances of width `AW+1`.
- No new sub-module.

## Test plan
All scenarios use DW=8, DP=4.
- Reset, then idle for 5 cycles → `valid_o`=0, `ready_i`=1, `cnt`=0, `data_o`=0.
- Push 0x11,0x22,0x33,0x44 with `ready_o`=0 → `cnt`=4, `ready_i`=0. A fifth `valid_i` with 0x55 is not accepted. Then `ready_o`=1 → outputs 0x11..0x44 in order, one per cycle, then `valid_o`=0.
- Continuous push of 0x00..0x0F with `ready_o`=1 → each beat appears on `data_o` one cycle after acceptance. `cnt` toggles between 1 and its steady value. Pointers wrap at least three times with no loss.
- Fill to 3 entries, then assert `flush` together with `valid_i`=0x99 and `ready_o`=1 → next cycle `cnt`=0 and `valid_o`=0. 0x99 is not stored and no pop is counted.
- Full FIFO with `ready_o`=1 and `valid_i`=0xAA:
  - With `GEN_PIPEFIFO_FULLPASS_EN`: `ready_i`=1 and 0xAA is accepted in the same cycle; `cnt` stays 4.
  - Without it: `ready_i`=0; 0xAA is accepted in the following cycle and `cnt` goes 4→3→4.
- Reset pulsed while `cnt`=2 and push/pop both active → next cycle `cnt`=0, `valid_o`=0, `data_o`=0.
